bp_unit: RTL and testbench

- Parametrised branch prediction unit for the fetch stage. Combines a gshare direction predictor, a direct-mapped branch target buffer with a jump bit, and misprediction detection for branches resolved in execute.
- Fetch supplies the current PC and receives a same-cycle prediction.
- Execute returns the resolved outcome, plus the prediction state it carried down the pipe, to train the tables.
- Prediction statistics counters are an optional feature.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_btb_dm.sv | 66 ++++++
 rtl/bp_unit.sv | 135 +++++++++++++
 tb/tb_bp_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch prediction unit.
// Optional statistics counters are enabled with BP_STATS_EN.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_state_t;

  function automatic pht_state_t sat_inc(pht_state_t s);
    return (s == ST) ? ST : pht_state_t'(s + 2'd1);
  endfunction

  function automatic pht_state_t sat_dec(pht_state_t s);
    return (s == SNT) ? SNT : pht_state_t'(s - 2'd1);
  endfunction

endpackage

// File: rtl/bp_btb_dm.sv
// Direct-mapped branch target buffer: async-reset valid bits,
// combinational lookup, single write port.
module bp_btb_dm
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] rd_pc,
  output logic            hit,
  output logic            hit_jump,
  output logic [XLEN-1:0] hit_target,
  input  logic            we,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_target,
  input  logic            wr_jump
);

  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic             is_jump;
  } btb_entry_t;

  logic [DEPTH-1:0] valid;
  btb_entry_t       mem [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  btb_entry_t       rd_ent;

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign rd_ent = mem[rd_idx];

  assign hit        = valid[rd_idx] &&
                      (rd_ent.tag == rd_pc[XLEN-1:IDX_W+2]);
  assign hit_jump   = rd_ent.is_jump;
  assign hit_target = rd_ent.target;

  // Only the valid bits need reset; payload is qualified by them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= '{tag:     wr_pc[XLEN-1:IDX_W+2],
                       target:  wr_target,
                       is_jump: wr_jump};
    end
  end

  logic lsb_unused;
  assign lsb_unused = ^{rd_pc[1:0], wr_pc[1:0]};

endmodule

// File: rtl/bp_unit.sv
// Gshare + direct-mapped BTB branch predictor for fetch.
// Define BP_STATS_EN to add saturating prediction statistics.
module bp_unit
  import bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHR_W     = 3,
  parameter int PHT_IDX_W = 7,
  parameter int BTB_IDX_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  output logic [BHR_W-1:0] pred_bhr,
  input  logic             upd_valid,
  input  logic             upd_is_br,
  input  logic             upd_is_jump,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic [BHR_W-1:0] upd_bhr,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  output logic             mispredict,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_correct,
  output logic [CNT_W-1:0] stat_incorrect
);

  localparam int PHT_N = 1 << PHT_IDX_W;

  logic is_br;
  logic ct;
  logic br_upd;

  // Both type bits set is resolved as a jump.
  assign is_br  = upd_is_br & ~upd_is_jump;
  assign ct     = upd_valid & (is_br | upd_is_jump);
  assign br_upd = ct & is_br;

  logic [BHR_W-1:0]     bhr;
  pht_state_t           pht [PHT_N];
  logic [PHT_IDX_W-1:0] fidx;
  logic [PHT_IDX_W-1:0] uidx;
  logic [1:0]           fstate;

  assign fidx   = fetch_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bhr);
  assign uidx   = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_bhr);
  assign fstate = pht[fidx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= WNT;
    end else if (br_upd) begin
      pht[uidx] <= upd_taken ? sat_inc(pht[uidx])
                             : sat_dec(pht[uidx]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bhr <= '0;
    end else if (br_upd) begin
      bhr <= {bhr[BHR_W-2:0], upd_taken};
    end
  end

  logic            hit;
  logic            hit_jump;
  logic [XLEN-1:0] hit_target;

  bp_btb_dm #(
    .XLEN  (XLEN),
    .IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_pc      (fetch_pc),
    .hit        (hit),
    .hit_jump   (hit_jump),
    .hit_target (hit_target),
    .we         (ct & upd_taken),
    .wr_pc      (upd_pc),
    .wr_target  (upd_target),
    .wr_jump    (upd_is_jump)
  );

  assign pred_taken  = hit & (hit_jump | fstate[1]);
  assign pred_target = hit ? hit_target : '0;
  assign pred_bhr    = bhr;

  assign mispredict = ct &
    ((upd_taken != upd_pred_taken) |
     (upd_taken & (upd_pred_target != upd_target)));

`ifdef BP_STATS_EN
  logic [CNT_W-1:0] tot_q;
  logic [CNT_W-1:0] cor_q;
  logic [CNT_W-1:0] inc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tot_q <= '0;
      cor_q <= '0;
      inc_q <= '0;
    end else if (stat_clr) begin
      tot_q <= '0;
      cor_q <= '0;
      inc_q <= '0;
    end else if (ct) begin
      if (tot_q != '1) tot_q <= tot_q + 1'b1;
      if (mispredict) begin
        if (inc_q != '1) inc_q <= inc_q + 1'b1;
      end else begin
        if (cor_q != '1) cor_q <= cor_q + 1'b1;
      end
    end
  end

  assign stat_total     = tot_q;
  assign stat_correct   = cor_q;
  assign stat_incorrect = inc_q;
`else
  logic stat_unused;
  assign stat_unused    = stat_clr;
  assign stat_total     = '0;
  assign stat_correct   = '0;
  assign stat_incorrect = '0;
`endif

endmodule

// File: tb/tb_bp_unit.sv
// Scoreboard bench for bp_unit: expected predictions queued per
// cycle, popped and compared at the falling edge.
module tb_bp_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [2:0]  pred_bhr;
  logic        upd_valid;
  logic        upd_is_br;
  logic        upd_is_jump;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [2:0]  upd_bhr;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic        stat_clr;
  logic [3:0]  stat_total;
  logic [3:0]  stat_correct;
  logic [3:0]  stat_incorrect;

  always #5 clk = ~clk;

  bp_unit #(
    .XLEN      (32),
    .BHR_W     (3),
    .PHT_IDX_W (7),
    .BTB_IDX_W (5),
    .CNT_W     (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .pred_bhr        (pred_bhr),
    .upd_valid       (upd_valid),
    .upd_is_br       (upd_is_br),
    .upd_is_jump     (upd_is_jump),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_bhr         (upd_bhr),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .stat_clr        (stat_clr),
    .stat_total      (stat_total),
    .stat_correct    (stat_correct),
    .stat_incorrect  (stat_incorrect)
  );

`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic        pt;
    logic [31:0] tgt;
    logic [2:0]  bhr;
    logic        mp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(string tag, logic pt, logic [31:0] tgt,
                      logic [2:0] bhr, logic mp);
    exp_t e;
    e.tag = tag;
    e.pt  = pt;
    e.tgt = tgt;
    e.bhr = bhr;
    e.mp  = mp;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".pt"},  {31'd0, pred_taken}, {31'd0, e.pt});
    check({e.tag, ".tgt"}, pred_target, e.tgt);
    check({e.tag, ".bhr"}, {29'd0, pred_bhr}, {29'd0, e.bhr});
    check({e.tag, ".mp"},  {31'd0, mispredict}, {31'd0, e.mp});
  endtask

  task automatic stats(string tag, int t, int c, int i);
    check({tag, ".total"}, {28'd0, stat_total},
          STATS ? t : 0);
    check({tag, ".correct"}, {28'd0, stat_correct},
          STATS ? c : 0);
    check({tag, ".incorrect"}, {28'd0, stat_incorrect},
          STATS ? i : 0);
  endtask

  task automatic idle();
    upd_valid       = 1'b0;
    upd_is_br       = 1'b0;
    upd_is_jump     = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_bhr         = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
  endtask

  task automatic upd(logic br, logic jmp, logic [31:0] pc,
                     logic tk, logic [31:0] tgt,
                     logic [2:0] ubhr, logic ptk,
                     logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_is_br       = br;
    upd_is_jump     = jmp;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_bhr         = ubhr;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  task automatic cyc();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    stat_clr = 1'b0;
    fetch_pc = 32'h60;
    idle();
    #12;
    push("reset", 1'b0, 0, 3'd0, 1'b0);
    compare();
    stats("reset", 0, 0, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // jump learned, visible one cycle later
    fetch_pc = 32'h100;
    upd(0, 1, 32'h100, 1, 32'h200, 3'd0, 0, 0);
    push("jl_same", 1'b0, 0, 3'd0, 1'b1);
    cyc();
    idle();
    push("jl_next", 1'b1, 32'h200, 3'd0, 1'b0);
    cyc();

    // async reset mid-operation, no clock edge in between
    reset_n = 1'b0;
    #2;
    push("arst", 1'b0, 0, 3'd0, 1'b0);
    compare();
    stats("arst", 0, 0, 0);
    reset_n = 1'b1;

    // PHT saturation at index 0x10^0x6
    fetch_pc = 32'h40;
    upd(1, 0, 32'h40, 1, 32'h80, 3'd6, 0, 0);
    push("pht1", 1'b0, 0, 3'd0, 1'b1);
    cyc();
    upd(1, 0, 32'h40, 1, 32'h80, 3'd6, 1, 32'h80);
    push("pht2", 1'b0, 32'h80, 3'd1, 1'b0);
    cyc();
    push("pht3", 1'b0, 32'h80, 3'd3, 1'b0);
    cyc();
    push("pht4", 1'b0, 32'h80, 3'd7, 1'b0);
    cyc();
    upd(1, 0, 32'h40, 0, 32'h80, 3'd6, 1, 32'h80);
    push("pht_nt", 1'b0, 32'h80, 3'd7, 1'b1);
    cyc();
    idle();
    push("pht_wt", 1'b1, 32'h80, 3'd6, 1'b0);
    cyc();

    // wrong target, then correct prediction
    fetch_pc = 32'h200;
    upd(0, 1, 32'h200, 1, 32'h304, 3'd6, 1, 32'h300);
    push("wt_same", 1'b0, 0, 3'd6, 1'b1);
    cyc();
    upd(0, 1, 32'h200, 1, 32'h304, 3'd6, 1, 32'h304);
    push("wt_next", 1'b1, 32'h304, 3'd6, 1'b0);
    cyc();

    // correctly predicted not-taken ignores target
    fetch_pc = 32'h44;
    upd(1, 0, 32'h44, 0, 32'h48, 3'd6, 0, 32'h999);
    push("nt_ok", 1'b0, 0, 3'd6, 1'b0);
    cyc();

    // BTB aliasing at index 0
    fetch_pc = 32'h100;
    upd(0, 1, 32'h100, 1, 32'h500, 3'd4, 0, 0);
    push("al_a", 1'b0, 0, 3'd4, 1'b1);
    cyc();
    upd(0, 1, 32'h180, 1, 32'h600, 3'd4, 0, 0);
    push("al_b", 1'b1, 32'h500, 3'd4, 1'b1);
    cyc();
    upd(0, 1, 32'h100, 1, 32'h500, 3'd4, 0, 0);
    upd_valid = 1'b0;
    push("al_c", 1'b0, 0, 3'd4, 1'b0);
    cyc();
    fetch_pc = 32'h180;
    idle();
    push("al_d", 1'b1, 32'h600, 3'd4, 1'b0);
    cyc();

    // both type bits: jump, no history shift
    fetch_pc = 32'h308;
    upd(1, 1, 32'h308, 1, 32'h700, 3'd4, 0, 0);
    push("both_same", 1'b0, 0, 3'd4, 1'b1);
    cyc();
    idle();
    push("both_next", 1'b1, 32'h700, 3'd4, 1'b0);
    cyc();

    @(negedge clk);
    stats("pre", 11, 5, 6);
    @(posedge clk);
    #1;

    // clear with a concurrent CT, then saturate
    stat_clr = 1'b1;
    fetch_pc = 32'h400;
    upd(0, 1, 32'h400, 1, 32'h800, 3'd4, 1, 32'h800);
    push("clr", 1'b0, 0, 3'd4, 1'b0);
    cyc();
    stat_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push("sat", 1'b1, 32'h800, 3'd4, 1'b0);
      @(negedge clk);
      compare();
      if (i == 0) stats("clr", 0, 0, 0);
      @(posedge clk);
      #1;
    end
    idle();
    @(negedge clk);
    stats("sat", 15, 15, 0);
    @(posedge clk);
    #1;

    upd(0, 1, 32'h400, 1, 32'h804, 3'd4, 1, 32'h800);
    push("inc", 1'b1, 32'h800, 3'd4, 1'b1);
    cyc();
    idle();
    @(negedge clk);
    stats("inc", 15, 15, 1);

    #1;
    reset_n = 1'b0;
    #2;
    stats("arst2", 0, 0, 0);
    push("arst2", 1'b0, 0, 3'd0, 1'b0);
    compare();
    reset_n = 1'b1;

    check("sb_left", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
